// File: rtl/hs_earom_ctrl.sv
// hs_earom_ctrl: sequencer/arbiter sharing a 64x8 high-score EAROM macro
// between the game CPU (single-strobe commands) and the host save/load port
// (req/ack handshake). Every write runs erase-then-write.
// Optional build macro HS_VERIFY_EN: read back after each write and flag a
// mismatch on the sticky verify_err output.
module hs_earom_ctrl #(
    parameter int unsigned ERASE_CYC = 4,
    parameter int unsigned WRITE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [5:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_busy,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [5:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       host_ack,
    output logic [5:0] ea_a,
    output logic [7:0] ea_din,
    input  logic [7:0] ea_dout,
    output logic       ea_cs1,
    output logic       ea_c1,
    output logic       ea_c2,
    output logic       ea_rclk
`ifdef HS_VERIFY_EN
    ,
    output logic       verify_err
`endif
);

    // Hold times of zero are stretched to one clock; counters reload with N-1.
    localparam int unsigned ERASE_EFF = (ERASE_CYC == 0) ? 1 : ERASE_CYC;
    localparam int unsigned WRITE_EFF = (WRITE_CYC == 0) ? 1 : WRITE_CYC;
    localparam logic [7:0]  ERASE_LD  = 8'(ERASE_EFF - 1);
    localparam logic [7:0]  WRITE_LD  = 8'(WRITE_EFF - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ERASE    = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_RD_PULSE = 3'd3;
    localparam logic [2:0] ST_RD_CAP   = 3'd4;
`ifdef HS_VERIFY_EN
    localparam logic [2:0] ST_VFY_PULSE = 3'd5;
    localparam logic [2:0] ST_VFY_CAP   = 3'd6;
`endif

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic       r_owner_host;
    logic [5:0] r_ea_a;
    logic [7:0] r_ea_din;
    logic       r_ea_cs1;
    logic       r_ea_c1;
    logic       r_ea_c2;
    logic       r_ea_rclk;

    logic       r_cpu_busy;
    logic       r_cpu_pend;
    logic       r_cpu_we;
    logic [5:0] r_cpu_addr;
    logic [7:0] r_cpu_wdata;
    logic [7:0] r_cpu_rdata;
    logic [7:0] r_host_rdata;
    logic       r_host_ack;

    logic [2:0] w_state_nx;
    logic [7:0] w_cnt_nx;
    logic       w_grant;
    logic       w_grant_host;
    logic       w_grant_we;
    logic       w_done;
    logic       w_cap;
    logic       w_host_go;
    logic       w_cpu_accept;
    logic       w_cs1_nx;
    logic       w_c1_nx;
    logic       w_c2_nx;
    logic       w_rclk_nx;
    logic [5:0] w_sel_addr;
    logic [7:0] w_sel_wdata;
`ifdef HS_VERIFY_EN
    logic       w_vfy_cap;
    logic       r_verify_err;
`endif

    // A held host_req is not re-sampled in its own ack cycle.
    assign w_host_go    = host_req && !r_host_ack;
    assign w_cpu_accept = cpu_req && !r_cpu_busy;
    assign w_sel_addr   = w_grant_host ? host_addr  : r_cpu_addr;
    assign w_sel_wdata  = w_grant_host ? host_wdata : r_cpu_wdata;
    assign w_grant_we   = w_grant_host ? host_we    : r_cpu_we;

    // Next-state logic: arbitration in IDLE, phase counting, completion flags.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_grant      = 1'b0;
        w_grant_host = 1'b0;
        w_done       = 1'b0;
        w_cap        = 1'b0;
`ifdef HS_VERIFY_EN
        w_vfy_cap    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_host_go) begin
                    w_grant      = 1'b1;
                    w_grant_host = 1'b1;
                end else if (r_cpu_pend) begin
                    w_grant      = 1'b1;
                end
                if (w_grant) begin
                    w_state_nx = w_grant_we ? ST_ERASE : ST_RD_PULSE;
                    w_cnt_nx   = ERASE_LD;
                end
            end
            ST_ERASE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nx = ST_WRITE;
                    w_cnt_nx   = WRITE_LD;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            ST_WRITE: begin
                if (r_cnt == 8'd0) begin
`ifdef HS_VERIFY_EN
                    w_state_nx = ST_VFY_PULSE;
`else
                    w_state_nx = ST_IDLE;
                    w_done     = 1'b1;
`endif
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            ST_RD_PULSE: begin
                w_state_nx = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                w_state_nx = ST_IDLE;
                w_done     = 1'b1;
                w_cap      = 1'b1;
            end
`ifdef HS_VERIFY_EN
            ST_VFY_PULSE: begin
                w_state_nx = ST_VFY_CAP;
            end
            ST_VFY_CAP: begin
                w_state_nx = ST_IDLE;
                w_done     = 1'b1;
                w_vfy_cap  = 1'b1;
            end
`endif
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Macro control pin decode for the state being entered.
    always_comb begin
        w_cs1_nx  = 1'b0;
        w_c1_nx   = 1'b1;
        w_c2_nx   = 1'b1;
        w_rclk_nx = 1'b0;
        case (w_state_nx)
            ST_ERASE: begin
                w_cs1_nx = 1'b1;
                w_c1_nx  = 1'b0;
                w_c2_nx  = 1'b1;
            end
            ST_WRITE: begin
                w_cs1_nx = 1'b1;
                w_c1_nx  = 1'b0;
                w_c2_nx  = 1'b0;
            end
            ST_RD_PULSE: begin
                w_cs1_nx  = 1'b1;
                w_c2_nx   = 1'b0;
                w_rclk_nx = 1'b1;
            end
            ST_RD_CAP: begin
                w_cs1_nx = 1'b1;
                w_c2_nx  = 1'b0;
            end
`ifdef HS_VERIFY_EN
            ST_VFY_PULSE: begin
                w_cs1_nx  = 1'b1;
                w_c2_nx   = 1'b0;
                w_rclk_nx = 1'b1;
            end
            ST_VFY_CAP: begin
                w_cs1_nx = 1'b1;
                w_c2_nx  = 1'b0;
            end
`endif
            default: begin
                w_cs1_nx = 1'b0;
            end
        endcase
    end

    // State, phase counter and registered macro control pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_ea_cs1  <= 1'b0;
            r_ea_c1   <= 1'b1;
            r_ea_c2   <= 1'b1;
            r_ea_rclk <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_ea_cs1  <= w_cs1_nx;
            r_ea_c1   <= w_c1_nx;
            r_ea_c2   <= w_c2_nx;
            r_ea_rclk <= w_rclk_nx;
        end
    end

    // Address/data and owner are loaded on grant and held until the next grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ea_a       <= 6'd0;
            r_ea_din     <= 8'd0;
            r_owner_host <= 1'b0;
        end else if (w_grant) begin
            r_ea_a       <= w_sel_addr;
            r_ea_din     <= w_sel_wdata;
            r_owner_host <= w_grant_host;
        end
    end

    // CPU command capture and busy tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_busy  <= 1'b0;
            r_cpu_pend  <= 1'b0;
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= 6'd0;
            r_cpu_wdata <= 8'd0;
        end else begin
            if (w_cpu_accept) begin
                r_cpu_busy  <= 1'b1;
                r_cpu_pend  <= 1'b1;
                r_cpu_we    <= cpu_we;
                r_cpu_addr  <= cpu_addr;
                r_cpu_wdata <= cpu_wdata;
            end else begin
                if (w_grant && !w_grant_host) begin
                    r_cpu_pend <= 1'b0;
                end
                if (w_done && !r_owner_host) begin
                    r_cpu_busy <= 1'b0;
                end
            end
        end
    end

    // Read results and host completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_rdata  <= 8'd0;
            r_host_rdata <= 8'd0;
            r_host_ack   <= 1'b0;
        end else begin
            r_host_ack <= w_done && r_owner_host;
            if (w_cap && r_owner_host) begin
                r_host_rdata <= ea_dout;
            end
            if (w_cap && !r_owner_host) begin
                r_cpu_rdata <= ea_dout;
            end
        end
    end

`ifdef HS_VERIFY_EN
    // Sticky read-back mismatch flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_verify_err <= 1'b0;
        end else if (w_vfy_cap && (ea_dout != r_ea_din)) begin
            r_verify_err <= 1'b1;
        end
    end

    assign verify_err = r_verify_err;
`endif

    assign ea_a       = r_ea_a;
    assign ea_din     = r_ea_din;
    assign ea_cs1     = r_ea_cs1;
    assign ea_c1      = r_ea_c1;
    assign ea_c2      = r_ea_c2;
    assign ea_rclk    = r_ea_rclk;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_busy   = r_cpu_busy;
    assign host_rdata = r_host_rdata;
    assign host_ack   = r_host_ack;

endmodule

// File: tb/tb_hs_earom_ctrl.sv
// Testbench for hs_earom_ctrl: behavioural EAROM macro, reference memory
// model, and a scoreboard monitor checking every completion.
module tb_hs_earom_ctrl;

    localparam int unsigned E_CYC = 4;
    localparam int unsigned W_CYC = 4;
`ifdef HS_VERIFY_EN
    localparam int unsigned VFY = 2;
`else
    localparam int unsigned VFY = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [5:0] cpu_addr = 6'd0;
    logic [7:0] cpu_wdata = 8'd0;
    logic [7:0] cpu_rdata;
    logic       cpu_busy;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [5:0] host_addr = 6'd0;
    logic [7:0] host_wdata = 8'd0;
    logic [7:0] host_rdata;
    logic       host_ack;
    logic [5:0] ea_a;
    logic [7:0] ea_din;
    logic [7:0] ea_dout = 8'd0;
    logic       ea_cs1;
    logic       ea_c1;
    logic       ea_c2;
    logic       ea_rclk;
`ifdef HS_VERIFY_EN
    logic       verify_err;
`endif

    hs_earom_ctrl #(.ERASE_CYC(E_CYC), .WRITE_CYC(W_CYC)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .ea_a(ea_a), .ea_din(ea_din), .ea_dout(ea_dout),
        .ea_cs1(ea_cs1), .ea_c1(ea_c1), .ea_c2(ea_c2), .ea_rclk(ea_rclk)
`ifdef HS_VERIFY_EN
        , .verify_err(verify_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural EAROM: erase clears the cell, write stores din, rclk registers dout.
    logic [7:0] mac_mem [64];
    logic       loaded = 1'b0;
    logic       corrupt = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mac_mem[i] <= 8'(i * 37 + 5);
            loaded <= 1'b1;
        end else begin
            if (ea_cs1 && !ea_c1 && ea_c2) mac_mem[ea_a] <= 8'h00;
            else if (ea_cs1 && !ea_c1 && !ea_c2) mac_mem[ea_a] <= ea_din;
            if (ea_rclk) ea_dout <= mac_mem[ea_a] ^ (corrupt ? 8'hFF : 8'h00);
        end
    end

    // Reference model of cell contents and expected completions.
    typedef struct {
        logic       rd;
        logic [7:0] data;
    } exp_t;
    logic [7:0] ref_mem [64];
    exp_t host_q[$];
    exp_t cpu_q[$];

    // Scoreboard monitor: pops on host_ack and on each cpu_busy fall.
    logic prev_busy = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
        end else begin
            if (host_ack) begin
                if (host_q.size() == 0) chk("host_ack_unexpected", 32'(1), 32'(0));
                else begin
                    mon_e = host_q.pop_front();
                    if (mon_e.rd) chk("host_rdata", 32'(host_rdata), 32'(mon_e.data));
                end
            end
            if (prev_busy && !cpu_busy) begin
                if (cpu_q.size() == 0) chk("cpu_done_unexpected", 32'(1), 32'(0));
                else begin
                    mon_e = cpu_q.pop_front();
                    if (mon_e.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.data));
                end
            end
            if (!ea_cs1) chk("idle_pins", 32'({ea_c1, ea_c2, ea_rclk}), 32'(3'b110));
            prev_busy = cpu_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wait();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (!cpu_busy) ok = 1'b1;
            else tick();
        end
        if (!ok) chk("cpu_busy_timeout", 32'(0), 32'(1));
    endtask

    task automatic cpu_op(input logic we, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        cpu_wait();
        e.rd = !we;
        e.data = ref_mem[a];
        cpu_q.push_back(e);
        if (we) ref_mem[a] = d;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic host_op(input logic we, input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        logic got;
        e.rd = !we;
        e.data = ref_mem[a];
        host_q.push_back(e);
        if (we) ref_mem[a] = d;
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (host_ack) got = 1'b1;
        end
        host_req = 1'b0;
        if (!got) chk("host_ack_timeout", 32'(0), 32'(1));
        tick();
    endtask

    // Expected {cs1,c1,c2,busy} in cycle k after a CPU write strobe.
    function automatic logic [3:0] exp_wr_pins(input int unsigned k);
        if (k == 1) return 4'b0111;
        if (k <= 1 + E_CYC) return 4'b1011;
        if (k <= 1 + E_CYC + W_CYC) return 4'b1001;
        if (k <= 1 + E_CYC + W_CYC + VFY) return 4'b1101;
        return 4'b0110;
    endfunction

    initial begin
        logic [5:0] ra;
        logic [7:0] rd;
        int unsigned rcnt;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);

        // Reset and idle
        repeat (3) tick();
        chk("rst_pins", 32'({ea_cs1, ea_c1, ea_c2, ea_rclk}), 32'(4'b0110));
        reset_n = 1'b1;
        tick();
        chk("rst_ea_a", 32'(ea_a), 32'(0));
        chk("rst_ea_din", 32'(ea_din), 32'(0));
        chk("rst_rdata", 32'({cpu_rdata, host_rdata}), 32'(0));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle10", 32'({ea_cs1, ea_c1, ea_c2, ea_rclk, cpu_busy, host_ack}), 32'(6'b011000));
        end
        tick();

        // CPU write 0x15=0xA5 with per-cycle pin timing
        cpu_op(1'b1, 6'h15, 8'hA5);
        for (int unsigned k = 1; k <= 2 + E_CYC + W_CYC + VFY; k++) begin
            @(negedge clk);
            chk("wr_pins", 32'({ea_cs1, ea_c1, ea_c2, cpu_busy}), 32'(exp_wr_pins(k)));
            if (k >= 2) chk("wr_addr_data", 32'({ea_a, ea_din}), 32'({6'h15, 8'hA5}));
        end
        tick();

        // CPU read back with a single rclk pulse
        cpu_op(1'b0, 6'h15, 8'h00);
        rcnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (ea_rclk) rcnt++;
        end
        chk("rd_rclk_count", 32'(rcnt), 32'(1));
        chk("rd_busy_done", 32'(cpu_busy), 32'(0));
        chk("rd_value", 32'(cpu_rdata), 32'(8'hA5));
        tick();

        // Same-cycle host read and CPU write: host first
        begin
            exp_t e;
            e.rd = 1'b1; e.data = ref_mem[6'h15]; host_q.push_back(e);
            e.rd = 1'b0; e.data = 8'h00; cpu_q.push_back(e);
            ref_mem[6'h2A] = 8'h3C;
        end
        host_we = 1'b0; host_addr = 6'h15; host_req = 1'b1;
        cpu_we = 1'b1; cpu_addr = 6'h2A; cpu_wdata = 8'h3C; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("arb_host_first", 32'({ea_rclk, ea_a}), 32'({1'b1, 6'h15}));
        @(negedge clk);
        @(negedge clk);
        chk("arb_host_ack", 32'(host_ack), 32'(1));
        host_req = 1'b0;
        @(negedge clk);
        chk("arb_cpu_next", 32'({ea_cs1, ea_c1, ea_c2, ea_a}), 32'({3'b101, 6'h2A}));
        tick();
        cpu_we = 1'b1; cpu_addr = 6'h2A; cpu_wdata = 8'hC3; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        cpu_wait();
        cpu_op(1'b0, 6'h2A, 8'h00);
        cpu_wait();

        // Host fills all cells with their address, then reads them back
        for (int a = 0; a < 64; a++) host_op(1'b1, 6'(a), 8'(a));
        for (int a = 0; a < 64; a++) host_op(1'b0, 6'(a), 8'h00);

        // Reset in the second ERASE clock leaves the cell erased
        cpu_wait();
        cpu_we = 1'b1; cpu_addr = 6'h07; cpu_wdata = 8'h99; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cs1", 32'(ea_cs1), 32'(0));
        ref_mem[6'h07] = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk("rst_mid_busy", 32'(cpu_busy), 32'(0));
        cpu_op(1'b0, 6'h07, 8'h00);
        cpu_wait();

`ifdef HS_VERIFY_EN
        chk("vfy_clear", 32'(verify_err), 32'(0));
        corrupt = 1'b1;
        host_op(1'b1, 6'h05, 8'h5A);
        corrupt = 1'b0;
        chk("vfy_set", 32'(verify_err), 32'(1));
        host_op(1'b1, 6'h06, 8'h11);
        chk("vfy_sticky", 32'(verify_err), 32'(1));
`endif

        // Randomized serial traffic from both requesters
        for (int n = 0; n < 80; n++) begin
            ra = 6'($urandom_range(0, 63));
            rd = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                cpu_op(1'($urandom_range(0, 1)), ra, rd);
                cpu_wait();
            end else begin
                host_op(1'($urandom_range(0, 1)), ra, rd);
            end
        end
        repeat (3) tick();
        chk("host_q_drained", 32'(host_q.size()), 32'(0));
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
